// File: rtl/ook_pkg.sv
// Shared types and constants for the OOK framer and modulator.
// Holds the FSM state enum, divider helpers and carrier increment.
package ook_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } ook_state_t;

    // Carrier phase step used by the modulator NCO.
    localparam logic [28:0] CARRIER_PHASE_INC = 29'd21_474_836;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/ook_baud_gen.sv
// Free-running baud counter producing a one-cycle strobe every DIV clocks.
// Never restarted by traffic; only reset clears it.
module ook_baud_gen
    import ook_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: wrap to zero after DIV-1.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ook_framer.sv
// Byte-to-bit framer for the OOK modulator: 1-entry holding buffer,
// start(1) / 8 data MSB-first / stop(0) bits, paced by the baud strobe.
module ook_framer
    import ook_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 100_000,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       clk_bund,
    output logic       ook_bit,
    output logic       busy,
    output logic       frame_done
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    if (CLK_HZ % BAUD != 0 || DIV < 2) begin : g_bad_div
        $error("ook_framer: CLK_HZ/BAUD must be an integer >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 4) begin : g_bad_stop
        $error("ook_framer: STOP_BITS must be 1..4");
    end

    logic       tick;
    ook_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] stop_q, stop_d;
    logic       ook_q, ook_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       last_stop;
    logic       take;
    logic       load;

    ook_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Next-state logic for buffer, FSM, shift register and keying bit.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        ook_d      = ook_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        last_stop = (state_q == STOP) && (stop_q == STOP_LAST);
        take = tick && buf_full_q
             && ((state_q == IDLE) || last_stop);
        load = din_valid && !buf_full_q;

        if (load) begin
            buf_d      = din;
            buf_full_d = 1'b1;
        end else if (take) begin
            buf_full_d = 1'b0;
        end

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (buf_full_q) begin
                        state_d = START;
                        shift_d = buf_q;
                        ook_d   = 1'b1;
                    end
                end
                START: begin
                    state_d = DATA;
                    idx_d   = 3'd7;
                    ook_d   = shift_q[7];
                    shift_d = {shift_q[6:0], 1'b0};
                end
                DATA: begin
                    if (idx_q == 3'd0) begin
                        state_d = STOP;
                        stop_d  = 2'd0;
                        ook_d   = 1'b0;
                    end else begin
                        idx_d   = idx_q - 3'd1;
                        ook_d   = shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        if (buf_full_q) begin
                            state_d = START;
                            shift_d = buf_q;
                            ook_d   = 1'b1;
                        end else begin
                            state_d = IDLE;
                            ook_d   = 1'b0;
                        end
                    end else begin
                        stop_d = stop_q + 2'd1;
                    end
                end
            endcase
        end
    end

    // Framer state registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_q     <= '0;
            ook_q      <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            ook_q      <= ook_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign din_ready  = ~buf_full_q;
    assign clk_bund   = tick;
    assign ook_bit    = ook_q;
    assign busy       = (state_q != IDLE) || buf_full_q;
    assign frame_done = tick && last_stop;

endmodule

// File: tb/tb_ook_framer.sv
// Directed bench for ook_framer with DIV=10.
// One instance with 1 stop bit, one with 2 stop bits.
module tb_ook_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic       vld = 1'b0;
    logic       sel = 1'b0;

    logic rdy1, bund1, ook1, busy1, done1;
    logic rdy2, bund2, ook2, busy2, done2;
    logic rdy, bund, ook, busy, done;

    int tests = 0;
    int fails = 0;

    logic       s_ook[400];
    logic       s_done[400];
    logic       s_bund[400];
    logic [7:0] tx[4];

    ook_framer #(
        .CLK_HZ(1000), .BAUD(100), .STOP_BITS(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .din_valid(vld && !sel), .din_ready(rdy1),
        .clk_bund(bund1), .ook_bit(ook1),
        .busy(busy1), .frame_done(done1)
    );

    ook_framer #(
        .CLK_HZ(1000), .BAUD(100), .STOP_BITS(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .din_valid(vld && sel), .din_ready(rdy2),
        .clk_bund(bund2), .ook_bit(ook2),
        .busy(busy2), .frame_done(done2)
    );

    assign rdy  = sel ? rdy2  : rdy1;
    assign bund = sel ? bund2 : bund1;
    assign ook  = sel ? ook2  : ook1;
    assign busy = sel ? busy2 : busy1;
    assign done = sel ? done2 : done1;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Feed n bytes from tx with valid held, record the line, then
    // compare against the frame sequence built from tx.
    task automatic stream(input int n, input int nstop,
                          input string name, output int stalls);
        int L, tot, ncyc, idx, nacc, s, j, k, b;
        logic acc, e, ed, eb;
        L = 9 + nstop;
        tot = n * L * 10;
        ncyc = tot + 30;
        idx = 0;
        nacc = 0;
        stalls = 0;
        din = tx[0];
        vld = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            acc = vld && rdy;
            if (vld && !rdy) stalls++;
            cyc();
            if (acc) begin
                nacc++;
                idx++;
                if (idx == n) vld = 1'b0;
                else din = tx[idx];
            end
            s_ook[c]  = ook;
            s_done[c] = done;
            s_bund[c] = bund;
        end
        vld = 1'b0;
        s = -1;
        for (int c = 0; c < ncyc; c++)
            if (s < 0 && s_ook[c]) s = c;
        chk({name, " latency"}, 32'((s >= 1) && (s <= 10)), 1);
        chk({name, " accepted"}, nacc, n);
        if (s < 0) s = 0;
        for (int c = 0; c < ncyc; c++) begin
            e = 1'b0;
            ed = 1'b0;
            if (c >= s && c < s + tot) begin
                j = (c - s) / 10;
                k = j % L;
                b = j / L;
                if (k == 0) e = 1'b1;
                else if (k <= 8) e = tx[b][8-k];
                ed = ((c - s + 1) % (L * 10)) == 0;
            end
            eb = ((c - s + 1 + 1000) % 10) == 0;
            chk($sformatf("%s ook c%0d", name, c), s_ook[c], e);
            chk($sformatf("%s done c%0d", name, c), s_done[c], ed);
            chk($sformatf("%s bund c%0d", name, c), s_bund[c], eb);
        end
        chk({name, " busy_end"}, busy, 0);
        chk({name, " ready_end"}, rdy, 1);
    endtask

    initial begin
        int st;
        int w;

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        chk("rst ook", ook1, 0);
        chk("rst busy", busy1, 0);
        chk("rst ready", rdy1, 1);
        chk("rst bund", bund1, 0);
        chk("rst done", done1, 0);
        chk("rst busy2", busy2, 0);
        repeat (3) cyc();
        rst_n = 1'b1;

        // Baud strobe from reset release, idle line.
        for (int i = 1; i <= 30; i++) begin
            cyc();
            chk($sformatf("baud k%0d", i), bund1, 32'((i % 10) == 9));
            chk($sformatf("idle ook k%0d", i), ook1, 0);
        end

        // Single byte.
        tx[0] = 8'hA5;
        stream(1, 1, "single", st);

        // Back-to-back.
        tx[0] = 8'hFF;
        tx[1] = 8'h00;
        stream(2, 1, "b2b", st);

        // Back-pressure with three bytes.
        tx[0] = 8'h3C;
        tx[1] = 8'hC3;
        tx[2] = 8'h81;
        stream(3, 1, "bp", st);
        chk("bp stalled", 32'(st > 0), 1);

        // Two stop bits.
        sel = 1'b1;
        tx[0] = 8'h01;
        stream(1, 2, "stop2", st);
        sel = 1'b0;

        // Reset during 4th data bit of 0x5A.
        din = 8'h5A;
        vld = 1'b1;
        cyc();
        vld = 1'b0;
        w = 0;
        while (!ook1 && w < 20) begin
            cyc();
            w++;
        end
        chk("mid start seen", ook1, 1);
        repeat (45) cyc();
        chk("mid pre ook", ook1, 1);
        chk("mid pre busy", busy1, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst ook", ook1, 0);
        chk("mid rst busy", busy1, 0);
        chk("mid rst ready", rdy1, 1);
        chk("mid rst done", done1, 0);
        chk("mid rst bund", bund1, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("post rst ook", ook1, 0);
        tx[0] = 8'h96;
        stream(1, 1, "after_rst", st);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
